// File: rtl/siggen_sweep_ctrl_if.sv
// siggen_sweep_ctrl_if: config/control inputs and counter-side outputs of the sweep sequencer.
interface siggen_sweep_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
    parameter int LEN_W = 16
);
    logic             start;
    logic             abort;
    logic             loop;
    logic [DIV_W-1:0] tick_div;
    logic [WIDTH-1:0] incr_start;
    logic [WIDTH-1:0] incr_end;
    logic [LEN_W-1:0] step_len;
    logic [LEN_W-1:0] hold_len;
    logic [WIDTH-1:0] offset_in;
    logic             cnt_rst;
    logic             cnt_en;
    logic [WIDTH-1:0] cnt_incr;
    logic [WIDTH-1:0] cnt_offset;
    logic             busy;
    logic             done;
    logic [2:0]       state;
    modport master (
        output start, abort, loop, tick_div, incr_start, incr_end, step_len, hold_len, offset_in,
        input  cnt_rst, cnt_en, cnt_incr, cnt_offset, busy, done, state
    );
    modport slave (
        input  start, abort, loop, tick_div, incr_start, incr_end, step_len, hold_len, offset_in,
        output cnt_rst, cnt_en, cnt_incr, cnt_offset, busy, done, state
    );
endinterface

// File: rtl/siggen_sweep_ctrl.sv
// siggen_sweep_ctrl: ramps the counter increment start->end, holds, ramps back, then pulses done.
// Define SWEEP_LOOP_EN to let the loop input restart the sweep from ARM instead of stopping.
module siggen_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16,
    parameter int LEN_W = 16
) (
    input logic clk,
    input logic rst,
    siggen_sweep_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        RAMP_UP   = 3'd2,
        HOLD      = 3'd3,
        RAMP_DOWN = 3'd4
    } state_t;

    state_t           cur, nxt;
    logic [DIV_W-1:0] div_r, psc, psc_n;
    logic [WIDTH-1:0] start_r, end_r, off_r;
    logic [WIDTH-1:0] incr, incr_n, off, off_n, tgt, step_v;
    logic [LEN_W-1:0] step_r, hold_r, cnt, cnt_n;
    logic             en, cnt_rst_r, busy_r, done_r, done_n;
    logic             load, active, tick, step_end, hold_end, flat, loop_go;

`ifdef SWEEP_LOOP_EN
    assign loop_go = bus.loop;
`else
    assign loop_go = 1'b0;
`endif

    // en is registered from the next-state prescaler match, so it is exactly this cycle's tick
    assign active   = cur inside {RAMP_UP, HOLD, RAMP_DOWN};
    assign tick     = en;
    assign flat     = start_r == end_r;
    assign tgt      = cur == RAMP_DOWN ? start_r : end_r;
    assign step_v   = incr < tgt ? incr + 1'b1 : incr - 1'b1;
    assign step_end = tick && cnt == step_r - 1'b1;
    assign hold_end = hold_r == '0 || (tick && cnt == hold_r - 1'b1);

    always_comb begin
        nxt    = cur;
        psc_n  = active ? (psc == div_r ? '0 : psc + 1'b1) : psc;
        cnt_n  = cnt;
        incr_n = incr;
        off_n  = off;
        done_n = 1'b0;
        load   = 1'b0;
        if (bus.abort && cur != IDLE) begin
            nxt = IDLE;
        end else begin
            case (cur)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        nxt    = ARM;
                        load   = 1'b1;
                        incr_n = bus.incr_start;
                        off_n  = bus.offset_in;
                    end
                end
                ARM: begin
                    nxt    = flat ? HOLD : RAMP_UP;
                    psc_n  = '0;
                    cnt_n  = '0;
                    incr_n = start_r;
                    off_n  = off_r;
                end
                RAMP_UP: begin
                    if (tick) cnt_n = step_end ? '0 : cnt + 1'b1;
                    if (step_end) begin
                        incr_n = step_v;
                        if (step_v == end_r) nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (tick) cnt_n = cnt + 1'b1;
                    if (hold_end) begin
                        cnt_n  = '0;
                        done_n = flat;
                        nxt    = flat ? IDLE : RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (tick) cnt_n = step_end ? '0 : cnt + 1'b1;
                    if (step_end) begin
                        incr_n = step_v;
                        if (step_v == start_r) begin
                            done_n = 1'b1;
                            nxt    = loop_go ? ARM : IDLE;
                        end
                    end
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= IDLE;
            psc       <= '0;
            cnt       <= '0;
            incr      <= '0;
            off       <= '0;
            en        <= 1'b0;
            cnt_rst_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            div_r     <= '0;
            start_r   <= '0;
            end_r     <= '0;
            off_r     <= '0;
            step_r    <= '0;
            hold_r    <= '0;
        end else begin
            cur       <= nxt;
            psc       <= psc_n;
            cnt       <= cnt_n;
            incr      <= incr_n;
            off       <= off_n;
            en        <= nxt inside {RAMP_UP, HOLD, RAMP_DOWN} && psc_n == div_r;
            cnt_rst_r <= nxt == ARM;
            busy_r    <= nxt != IDLE;
            done_r    <= done_n;
            if (load) begin
                div_r   <= bus.tick_div;
                start_r <= bus.incr_start;
                end_r   <= bus.incr_end;
                off_r   <= bus.offset_in;
                step_r  <= bus.step_len == '0 ? LEN_W'(1) : bus.step_len;
                hold_r  <= bus.hold_len;
            end
        end
    end

    assign bus.state      = cur;
    assign bus.cnt_en     = en;
    assign bus.cnt_rst    = cnt_rst_r;
    assign bus.cnt_incr   = incr;
    assign bus.cnt_offset = off;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_siggen_sweep_ctrl.sv
// tb_siggen_sweep_ctrl: directed sweeps; expected counter events are queued and checked by a monitor.
module tb_siggen_sweep_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    siggen_sweep_ctrl_if #(.WIDTH(8), .DIV_W(16), .LEN_W(16)) bus ();
    siggen_sweep_ctrl #(.WIDTH(8), .DIV_W(16), .LEN_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam int K_RST = 0, K_EN = 1, K_DONE = 2;

    typedef struct {int cyc; int kind; int incr; int st;} ev_t;
    typedef struct {string name; int act; int exp;} chk_t;

    ev_t  exp_q[$];
    chk_t chk_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   sum = 0;
    int   sum0 = 0;
    int   t0 = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic see(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got cyc=%0d kind=%0d incr=%0d state=%0d, expected none",
                     cyc, kind, bus.cnt_incr, bus.state);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != kind || e.incr != int'(bus.cnt_incr) || e.st != int'(bus.state)) begin
                fails++;
                $display("FAIL event: got cyc=%0d kind=%0d incr=%0d state=%0d, expected cyc=%0d kind=%0d incr=%0d state=%0d",
                         cyc, kind, bus.cnt_incr, bus.state, e.cyc, e.kind, e.incr, e.st);
            end
        end
    endtask

    // monitor: direct checks from the stimulus plus every done / cnt_rst / cnt_en event
    always @(negedge clk) begin
        while (chk_q.size() != 0) begin
            chk_t c;
            c = chk_q.pop_front();
            tests++;
            if (c.act != c.exp) begin
                fails++;
                $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
            end
        end
        if (mon_en) begin
            if (bus.done) see(K_DONE);
            if (bus.cnt_rst) see(K_RST);
            if (bus.cnt_en) begin
                see(K_EN);
                sum += int'(bus.cnt_incr);
            end
        end
    end

    task automatic push(input int c, input int k, input int incr, input int st);
        exp_q.push_back('{c, k, incr, st});
    endtask

    task automatic chk(input string n, input int a, input int e);
        chk_q.push_back('{n, a, e});
    endtask

    task automatic launch(input int dv, input int s, input int e, input int sl, input int hl, input int off);
        @(negedge clk);
        bus.tick_div   = 16'(dv);
        bus.incr_start = 8'(s);
        bus.incr_end   = 8'(e);
        bus.step_len   = 16'(sl);
        bus.hold_len   = 16'(hl);
        bus.offset_in  = 8'(off);
        bus.start      = 1'b1;
        t0             = cyc;
        sum0           = sum;
    endtask

    task automatic rel();
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk(n, exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_checks(input string n, input int incr);
        chk({n, "_state"}, int'(bus.state), 0);
        chk({n, "_busy"}, int'(bus.busy), 0);
        chk({n, "_cnt_en"}, int'(bus.cnt_en), 0);
        chk({n, "_done"}, int'(bus.done), 0);
        chk({n, "_cnt_incr"}, int'(bus.cnt_incr), incr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.loop = 0; bus.tick_div = 0;
        bus.incr_start = 0; bus.incr_end = 0; bus.step_len = 0; bus.hold_len = 0; bus.offset_in = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_checks("reset", 0);
        chk("reset_cnt_rst", int'(bus.cnt_rst), 0);
        mon_en = 1'b1;

        // basic sweep 2 -> 4 -> 2, two ticks per step, three hold ticks
        launch(0, 2, 4, 2, 3, 8'h11);
        push(t0 + 1, K_RST, 2, 1);
        push(t0 + 2, K_EN, 2, 2);  push(t0 + 3, K_EN, 2, 2);
        push(t0 + 4, K_EN, 3, 2);  push(t0 + 5, K_EN, 3, 2);
        push(t0 + 6, K_EN, 4, 3);  push(t0 + 7, K_EN, 4, 3);  push(t0 + 8, K_EN, 4, 3);
        push(t0 + 9, K_EN, 4, 4);  push(t0 + 10, K_EN, 4, 4);
        push(t0 + 11, K_EN, 3, 4); push(t0 + 12, K_EN, 3, 4);
        push(t0 + 13, K_DONE, 2, 0);
        rel();
        drain("basic_drain");
        chk("basic_count1", sum - sum0, 36);
        chk("basic_offset", int'(bus.cnt_offset), 8'h11);

        // prescaler div=2, flat sweep: only hold ticks, no ramp states
        launch(2, 5, 5, 1, 2, 0);
        push(t0 + 1, K_RST, 5, 1);
        push(t0 + 4, K_EN, 5, 3);
        push(t0 + 7, K_EN, 5, 3);
        push(t0 + 8, K_DONE, 5, 0);
        rel();
        drain("presc_drain");

        // descending ramp at the top of the range, step_len=0, hold_len=0
        launch(0, 255, 253, 0, 0, 0);
        push(t0 + 1, K_RST, 255, 1);
        push(t0 + 2, K_EN, 255, 2); push(t0 + 3, K_EN, 254, 2);
        push(t0 + 4, K_EN, 253, 3);
        push(t0 + 5, K_EN, 253, 4); push(t0 + 6, K_EN, 254, 4);
        push(t0 + 7, K_DONE, 255, 0);
        rel();
        drain("reverse_drain");
        chk("reverse_final_incr", int'(bus.cnt_incr), 255);

        // start during RAMP_UP is ignored; abort in HOLD returns to IDLE without done
        launch(0, 10, 12, 2, 5, 0);
        push(t0 + 1, K_RST, 10, 1);
        push(t0 + 2, K_EN, 10, 2); push(t0 + 3, K_EN, 10, 2);
        push(t0 + 4, K_EN, 11, 2); push(t0 + 5, K_EN, 11, 2);
        push(t0 + 6, K_EN, 12, 3); push(t0 + 7, K_EN, 12, 3);
        rel();
        while (cyc < t0 + 3) @(negedge clk);
        bus.incr_start = 50; bus.incr_end = 100; bus.step_len = 1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 7) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        idle_checks("abort", 12);
        drain("abort_drain");

        // abort and start together in IDLE: nothing starts
        @(negedge clk);
        bus.incr_start = 3; bus.incr_end = 6; bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 0;
        chk("abort_start_state", int'(bus.state), 0);
        chk("abort_start_cnt_rst", int'(bus.cnt_rst), 0);
        repeat (3) @(negedge clk);
        chk("abort_start_busy", int'(bus.busy), 0);

        // reset mid-sweep
        mon_en = 1'b0;
        launch(0, 2, 4, 2, 3, 0);
        rel();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_checks("midrst", 0);
        @(negedge clk);
        mon_en = 1'b1;

`ifdef SWEEP_LOOP_EN
        // looping sweep 1 -> 2 -> 1, loop dropped during the second pass
        bus.loop = 1'b1;
        launch(0, 1, 2, 1, 0, 0);
        push(t0 + 1, K_RST, 1, 1);
        push(t0 + 2, K_EN, 1, 2); push(t0 + 3, K_EN, 2, 3); push(t0 + 4, K_EN, 2, 4);
        push(t0 + 5, K_DONE, 1, 1); push(t0 + 5, K_RST, 1, 1);
        push(t0 + 6, K_EN, 1, 2); push(t0 + 7, K_EN, 2, 3); push(t0 + 8, K_EN, 2, 4);
        push(t0 + 9, K_DONE, 1, 0);
        rel();
        while (cyc < t0 + 5) @(negedge clk);
        chk("loop_busy", int'(bus.busy), 1);
        @(negedge clk);
        bus.loop = 1'b0;
        drain("loop_drain");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/siggen_sweep_ctrl.md
Name: siggen_sweep_ctrl

Overview:
Sequencer for the signal-generator address counter (en/incr/offset/rst interface). Runs a frequency sweep:
- ramps the phase increment from a start value to an end value,
- holds at the end value,
- ramps back to the start value, then signals done.

A programmable prescaler sets the sample rate: one counter enable per tick. The block sits between the top-level config/control and the counter that addresses the waveform ROM.

Parameters:
WIDTH, 8, width of increment/offset (matches counter WIDTH)
DIV_W, 16, width of prescaler divisor
LEN_W, 16, width of step/hold length fields

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  stop immediately, return to IDLE
loop  in  1  restart sweep instead of stopping (used only with SWEEP_LOOP_EN)
tick_div  in  DIV_W  sample tick every tick_div+1 clk cycles
incr_start  in  WIDTH  initial/final increment
incr_end  in  WIDTH  peak increment
step_len  in  LEN_W  ticks per increment step (0 treated as 1)
hold_len  in  LEN_W  ticks spent in HOLD
offset_in  in  WIDTH  phase offset for second channel
cnt_rst  out  1  counter reset
cnt_en  out  1  counter enable
cnt_incr  out  WIDTH  counter increment
cnt_offset  out  WIDTH  counter offset
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse at sweep completion
state  out  3  current FSM state encoding

Behaviour:
- All outputs registered. Reset values:
  - state=IDLE; cnt_rst=0, cnt_en=0, busy=0, done=0.
  - cnt_incr=0, cnt_offset=0; prescaler and step/hold counters 0.
- States: IDLE=0, ARM=1, RAMP_UP=2, HOLD=3, RAMP_DOWN=4.
- IDLE + start=1 (cycle T):
  - latch tick_div, incr_start, incr_end, step_len (0->1), hold_len, offset_in.
  - Go to ARM at T+1.
  - Inputs are not re-sampled until the next start.
- ARM, one cycle:
  - cnt_rst=1, cnt_en=0, cnt_incr=incr_start, cnt_offset=offset.
  - Prescaler and step counter cleared.
  - Next state is HOLD if incr_start==incr_end, else RAMP_UP.
- Prescaler:
  - Counts 0..div in RAMP_UP/HOLD/RAMP_DOWN; tick when count==div, then wraps to 0.
  - Not cleared between ramp/hold states.
  - div=0 gives a tick every cycle.
- cnt_en equals tick in RAMP_UP/HOLD/RAMP_DOWN; 0 in IDLE/ARM.
- RAMP_UP:
  - Each tick increments the step counter.
  - At step end (step_cnt==step_len-1 on a tick): cnt_incr moves 1 toward incr_end (up or down, since start>end is legal); step counter clears.
  - If the new value equals incr_end, go to HOLD.
- HOLD:
  - Counts ticks; after hold_len ticks, go to RAMP_DOWN.
  - hold_len=0: leaves HOLD the cycle after entry, regardless of ticks.
  - If incr_start==incr_end, go directly to IDLE+done instead of RAMP_DOWN.
- RAMP_DOWN:
  - Mirror of RAMP_UP, moving toward incr_start.
  - Reaching incr_start: go to IDLE, with done=1 for exactly that first IDLE cycle.
- No wrap-around on cnt_incr: steps are ±1 toward the target only. WIDTH-bit, unsigned.
- start while busy: ignored.
- abort (any non-IDLE state): next cycle IDLE; cnt_en=0, done=0. cnt_incr/cnt_offset keep their last values.
- abort and start in the same cycle while IDLE: abort wins, start is ignored.
- rst has priority over everything, including mid-sweep.

Optional Feature:
SWEEP_LOOP_EN
- Defined: at RAMP_DOWN completion, if loop=1, pulse done and go to ARM, which re-pulses cnt_rst and starts the next sweep with the latched config. If loop=0, go to IDLE as normal.
- Undefined: the loop port is ignored; every sweep ends in IDLE.

Test Plan:
- Reset: assert rst 2 cycles mid-sweep -> next cycle state=0, busy=0, cnt_en=0, cnt_incr=0, done=0.
- Basic sweep: div=0, start=2, end=4, step_len=2, hold_len=3, start at T -> ARM at T+1 (cnt_rst=1), cnt_incr per enabled cycle 2,2,3,3,4,4,4,4,4,3,3 (T+2..T+12), done at T+13. Counter count1 = 36.
- Prescaler: div=2, start=end=5, hold_len=2 -> cnt_en high on cycles T+4 and T+7 only, then done at T+8, no RAMP states entered.
- Reverse/boundary: start=255, end=253, step_len=0 (->1), hold_len=0, div=0 -> cnt_incr 255,254, then HOLD (1 cycle, no hold ticks), then RAMP_DOWN 253,254, then IDLE with done. Value never wraps past 255.
- Abort/ignore: abort during HOLD -> IDLE next cycle with no done pulse. start asserted during RAMP_UP has no effect on latched config.
- SWEEP_LOOP_EN with loop=1 -> done pulses each sweep, ARM re-entered (cnt_rst pulse), busy stays high. Dropping loop ends the sweep in IDLE.
